// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and operand-forward select encodings for the hazard unit
package hazard_pkg;
  typedef enum logic [1:0] {IDLE, MEM_WAIT, REFILL} miss_state_t;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
endpackage

// File: rtl/miss_sequencer.sv
// miss_sequencer: data-cache miss FSM that freezes the pipeline while a line is fetched and refilled
module miss_sequencer
  import hazard_pkg::*;
#(
  parameter int MISS_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic CacheMissM,
  output logic freeze,
  output logic MemReqM,
  output logic CacheRefillM
);
  localparam int CW = $clog2(MISS_LATENCY + 1);
  miss_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (CacheMissM) begin
        state_d = MEM_WAIT;
        cnt_d   = CW'(MISS_LATENCY - 1);
      end
      MEM_WAIT: if (cnt_q == '0) state_d = REFILL;
                else cnt_d = cnt_q - 1'b1;
      REFILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are masked by rst so a reset mid-miss drops the request immediately
  always_comb begin
    freeze       = ~rst & ((state_q == IDLE & CacheMissM) | state_q != IDLE);
    MemReqM      = ~rst & (state_q == MEM_WAIT);
    CacheRefillM = ~rst & (state_q == REFILL);
  end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward control for the five-stage pipeline plus cache-miss freeze
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MISS_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       ResultSrcE0,
  input  logic       PCSrcE,
  input  logic       CacheMissM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       StallW,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MemReqM,
  output logic       CacheRefillM
);
  logic freeze, lw_stall;
  miss_sequencer #(.MISS_LATENCY(MISS_LATENCY)) u_seq (
    .clk          (clk),
    .rst          (rst),
    .CacheMissM   (CacheMissM),
    .freeze       (freeze),
    .MemReqM      (MemReqM),
    .CacheRefillM (CacheRefillM)
  );
  always_comb begin
    ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? FWD_M :
                (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? FWD_W : FWD_NONE;
    ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? FWD_M :
                (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? FWD_W : FWD_NONE;
    lw_stall  = ResultSrcE0 & (RdE != 5'd0) & (RdE == Rs1D | RdE == Rs2D);
    // a taken branch discards F/D, so it must not also be stalled or CLR is ignored
    StallF    = freeze | (~rst & lw_stall & ~PCSrcE);
    StallD    = StallF;
    StallE    = freeze;
    StallM    = freeze;
    StallW    = freeze;
    FlushD    = rst | (~freeze & PCSrcE);
    FlushE    = rst | (~freeze & (lw_stall | PCSrcE));
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors with a queued scoreboard checked by an independent monitor
module tb_hazard_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, CacheMissM;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemReqM, CacheRefillM;
  logic [1:0] ForwardAE, ForwardBE;
  int checks = 0, failures = 0;
  string nq[$];
  logic [12:0] eq[$];

  hazard_unit #(.MISS_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .CacheMissM(CacheMissM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemReqM(MemReqM), .CacheRefillM(CacheRefillM)
  );

  always #5 clk = ~clk;

  // expected layout: stalls F,D,E,M,W _ flushes D,E _ fwdA _ fwdB _ memreq,refill
  logic [12:0] got;
  assign got = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
                ForwardAE, ForwardBE, MemReqM, CacheRefillM};

  always @(negedge clk) begin
    if (eq.size() != 0) begin
      string n;
      logic [12:0] e;
      n = nq.pop_front();
      e = eq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", n, got, e);
      end
    end
  end

  task automatic chk(input string n, input logic [12:0] e);
    nq.push_back(n);
    eq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, CacheMissM} = '0;
  endtask

  initial begin
    clear_in();
    @(posedge clk);
    #1;
    chk("reset0", 13'b00000_11_00_00_00);
    CacheMissM = 1'b1;
    chk("reset_miss", 13'b00000_11_00_00_00);
    CacheMissM = 1'b0;
    rst = 1'b0;
    chk("idle", 13'b00000_00_00_00_00);
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5;
    chk("fwd_m_prio", 13'b00000_00_10_00_00);
    RegWriteM = 0;
    chk("fwd_w", 13'b00000_00_01_00_00);
    Rs2E = 5;
    chk("fwd_w_both", 13'b00000_00_01_01_00);
    RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    chk("fwd_x0", 13'b00000_00_00_00_00);
    RdM = 3; Rs2E = 3; RdW = 4; Rs1E = 4;
    chk("fwd_mixed", 13'b00000_00_01_10_00);
    clear_in();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    chk("loaduse", 13'b11000_01_00_00_00);
    ResultSrcE0 = 0;
    chk("loaduse_gone", 13'b00000_00_00_00_00);
    ResultSrcE0 = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
    chk("loaduse_x0", 13'b00000_00_00_00_00);
    RdE = 7; Rs1D = 7; PCSrcE = 1;
    chk("branch_lw", 13'b00000_11_00_00_00);
    ResultSrcE0 = 0;
    chk("branch", 13'b00000_11_00_00_00);
    clear_in();
    CacheMissM = 1;
    chk("miss_c0", 13'b11111_00_00_00_00);
    CacheMissM = 0;
    for (int i = 1; i <= 4; i++) chk("miss_wait", 13'b11111_00_00_00_10);
    chk("miss_refill", 13'b11111_00_00_00_01);
    chk("miss_release", 13'b00000_00_00_00_00);
    CacheMissM = 1; PCSrcE = 1;
    chk("br_miss_c0", 13'b11111_00_00_00_00);
    CacheMissM = 0;
    for (int i = 1; i <= 4; i++) chk("br_miss_wait", 13'b11111_00_00_00_10);
    chk("br_miss_refill", 13'b11111_00_00_00_01);
    chk("br_miss_release", 13'b00000_11_00_00_00);
    clear_in();
    CacheMissM = 1;
    chk("b2b_c0", 13'b11111_00_00_00_00);
    for (int i = 1; i <= 4; i++) chk("b2b_wait_a", 13'b11111_00_00_00_10);
    chk("b2b_refill_a", 13'b11111_00_00_00_01);
    chk("b2b_restart", 13'b11111_00_00_00_00);
    CacheMissM = 0;
    for (int i = 1; i <= 4; i++) chk("b2b_wait_b", 13'b11111_00_00_00_10);
    chk("b2b_refill_b", 13'b11111_00_00_00_01);
    chk("b2b_release", 13'b00000_00_00_00_00);
    CacheMissM = 1;
    chk("rmiss_c0", 13'b11111_00_00_00_00);
    CacheMissM = 0;
    chk("rmiss_w1", 13'b11111_00_00_00_10);
    chk("rmiss_w2", 13'b11111_00_00_00_10);
    rst = 1;
    chk("rmiss_rst_w3", 13'b00000_11_00_00_00);
    chk("rmiss_rst_idle", 13'b00000_11_00_00_00);
    rst = 0;
    for (int i = 0; i < 4; i++) chk("rmiss_no_refill", 13'b00000_00_00_00_00);
    checks++;
    if (eq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
